// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR decoder: FSM states, microsecond
// timing windows and the window-match helper.
package ir_pkg;

  localparam int US_W = 14;
  typedef logic [US_W-1:0] us_t;

  localparam us_t US_SAT         = '1;
  localparam us_t TIMEOUT_US     = 14'd10000;

  localparam us_t LEAD_MARK_MIN  = 14'd8000;
  localparam us_t LEAD_MARK_MAX  = 14'd10000;
  localparam us_t DATA_SPACE_MIN = 14'd4000;
  localparam us_t DATA_SPACE_MAX = 14'd5000;
  localparam us_t REP_SPACE_MIN  = 14'd1800;
  localparam us_t REP_SPACE_MAX  = 14'd2700;
  localparam us_t BIT_MARK_MIN   = 14'd350;
  localparam us_t BIT_MARK_MAX   = 14'd800;
  localparam us_t BIT0_MIN       = 14'd350;
  localparam us_t BIT0_MAX       = 14'd800;
  localparam us_t BIT1_MIN       = 14'd1400;
  localparam us_t BIT1_MAX       = 14'd2000;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    FINISH,
    REP_MARK
  } state_t;

  function automatic logic in_win(input us_t us, input us_t lo, input us_t hi);
    return (us >= lo) && (us <= hi);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Synchronizes the active-low IR line, flags mark start/end edges and
// measures the current mark/space length in saturating microsecond ticks.
module ir_pulse_timer
  import ir_pkg::*;
#(
  parameter int TICK_CYCLES = 74
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic mark_start,
  output logic mark_end,
  output us_t  us_count
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level_p2;
  logic [PW-1:0] pre;
  logic          edge_seen;

  // Line idles high; presetting the chain to 1 avoids a false edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= 1'b1;
      sync_p1  <= 1'b1;
      level_p2 <= 1'b1;
    end else begin
      sync_p0  <= rx;
      sync_p1  <= sync_p0;
      level_p2 <= sync_p1;
    end
  end

  assign mark_start = level_p2 & ~sync_p1;
  assign mark_end   = ~level_p2 & sync_p1;
  assign edge_seen  = mark_start | mark_end;

  // us_count still holds the finished interval's length during the edge cycle.
  always_ff @(posedge clk) begin
    if (rst || edge_seen) begin
      pre      <= '0;
      us_count <= '0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      if (us_count != US_SAT) us_count <= us_count + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: classifies leader/repeat/data intervals, assembles
// the 32-bit code and pulses valid, repeat and error strobes.
module nec_ir_decoder
  import ir_pkg::*;
#(
  parameter int   TICK_CYCLES   = 74,
  parameter logic CHECK_INVERSE = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ir_rx_in,
  output logic [31:0] ir_out,
  output logic        valid_out,
  output logic        repeat_out,
  output logic        error_out
);

  logic        mark_start;
  logic        mark_end;
  us_t         us_count;

  state_t      state, state_nxt;
  logic [4:0]  bit_cnt, bit_cnt_nxt;
  logic [31:0] code, code_nxt;
  logic [31:0] ir_nxt;
  logic        have_code, have_code_nxt;
  logic        valid_nxt, repeat_nxt, error_nxt;
  logic        timeout;
  logic        inverse_ok;

  ir_pulse_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
    .clk        (clk_in),
    .rst        (rst_in),
    .rx         (ir_rx_in),
    .mark_start (mark_start),
    .mark_end   (mark_end),
    .us_count   (us_count)
  );

  assign inverse_ok = !CHECK_INVERSE || (code[15:8] == ~code[7:0]);
  assign timeout = (state inside {LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE}) &&
                   (us_count > TIMEOUT_US) && !mark_start && !mark_end;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      have_code  <= 1'b0;
      ir_out     <= '0;
      valid_out  <= 1'b0;
      repeat_out <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      have_code  <= have_code_nxt;
      ir_out     <= ir_nxt;
      valid_out  <= valid_nxt;
      repeat_out <= repeat_nxt;
      error_out  <= error_nxt;
    end
  end

  // Shift register is pure data and is always fully overwritten before use.
  always_ff @(posedge clk_in) begin
    code <= code_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    code_nxt      = code;
    ir_nxt        = ir_out;
    have_code_nxt = have_code;
    valid_nxt     = 1'b0;
    repeat_nxt    = 1'b0;
    error_nxt     = 1'b0;

    if (timeout) begin
      error_nxt = 1'b1;
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (mark_start) state_nxt = LEAD_MARK;

        LEAD_MARK: if (mark_end) begin
          if (in_win(us_count, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_nxt = LEAD_SPACE;
          else begin
            error_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end

        LEAD_SPACE: if (mark_start) begin
          if (in_win(us_count, DATA_SPACE_MIN, DATA_SPACE_MAX)) begin
            bit_cnt_nxt = '0;
            state_nxt   = BIT_MARK;
          end else if (in_win(us_count, REP_SPACE_MIN, REP_SPACE_MAX)) begin
            state_nxt = REP_MARK;
          end else begin
            error_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end

        BIT_MARK: if (mark_end) begin
          if (in_win(us_count, BIT_MARK_MIN, BIT_MARK_MAX)) state_nxt = BIT_SPACE;
          else begin
            error_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end

        // The mark that ends a space decides that bit; after bit 31 it is the stop mark.
        BIT_SPACE: if (mark_start) begin
          if (in_win(us_count, BIT0_MIN, BIT0_MAX) || in_win(us_count, BIT1_MIN, BIT1_MAX)) begin
            code_nxt    = {code[30:0], in_win(us_count, BIT1_MIN, BIT1_MAX)};
            bit_cnt_nxt = bit_cnt + 1'b1;
            state_nxt   = (bit_cnt == 5'd31) ? FINISH : BIT_MARK;
          end else begin
            error_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end

        FINISH: begin
          if (inverse_ok) begin
            ir_nxt        = code;
            valid_nxt     = 1'b1;
            have_code_nxt = 1'b1;
          end else begin
            error_nxt = 1'b1;
          end
          state_nxt = IDLE;
        end

        REP_MARK: begin
          if (have_code) repeat_nxt = 1'b1;
          else           error_nxt  = 1'b1;
          state_nxt = IDLE;
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Directed bench for nec_ir_decoder at 4 clocks per microsecond; a second
// instance runs with the inverse check disabled on the same IR line.
`timescale 1ns/1ps
module tb_nec_ir_decoder;

  localparam int TK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir  = 1'b1;
  logic [31:0] ir_out, ir_out2;
  logic        valid, rep, err;
  logic        valid2, rep2, err2;

  int n_chk = 0, n_err = 0;
  int n_valid = 0, n_rep = 0, n_errp = 0, n_valid2 = 0, n_multi = 0;
  int v0, r0, e0, w0;

  always #5 clk = ~clk;

  nec_ir_decoder #(.TICK_CYCLES(TK), .CHECK_INVERSE(1'b1)) dut (
    .clk_in(clk), .rst_in(rst), .ir_rx_in(ir),
    .ir_out(ir_out), .valid_out(valid), .repeat_out(rep), .error_out(err)
  );

  nec_ir_decoder #(.TICK_CYCLES(TK), .CHECK_INVERSE(1'b0)) dut_noinv (
    .clk_in(clk), .rst_in(rst), .ir_rx_in(ir),
    .ir_out(ir_out2), .valid_out(valid2), .repeat_out(rep2), .error_out(err2)
  );

  always @(posedge clk) begin
    if (valid)  n_valid  <= n_valid + 1;
    if (rep)    n_rep    <= n_rep + 1;
    if (err)    n_errp   <= n_errp + 1;
    if (valid2) n_valid2 <= n_valid2 + 1;
    if (int'(valid) + int'(rep) + int'(err) > 1) n_multi <= n_multi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int us);
    ir = v;
    repeat (us * TK) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    hold(1'b0, 562);
    hold(1'b1, b ? 1687 : 562);
  endtask

  task automatic send_frame(input logic [31:0] c);
    hold(1'b0, 9000);
    hold(1'b1, 4500);
    for (int i = 31; i >= 0; i--) send_bit(c[i]);
    hold(1'b0, 562);
    hold(1'b1, 3000);
  endtask

  task automatic send_repeat();
    hold(1'b0, 9000);
    hold(1'b1, 2250);
    hold(1'b0, 562);
    hold(1'b1, 3000);
  endtask

  task automatic snap();
    v0 = n_valid;
    r0 = n_rep;
    e0 = n_errp;
    w0 = n_valid2;
  endtask

  initial begin
    logic [31:0] c;
    repeat (5) @(negedge clk);
    chk("rst_ir_out", ir_out, 32'h0);
    chk("rst_strobes", {29'd0, valid, rep, err}, 32'h0);
    rst = 1'b0;
    hold(1'b1, 100);

    snap();
    send_repeat();
    chk("rep_no_code_err", n_errp - e0, 1);
    chk("rep_no_code_rep", n_rep - r0, 0);

    snap();
    send_frame(32'h20DF_5BA4);
    chk("frame1_valid", n_valid - v0, 1);
    chk("frame1_err", n_errp - e0, 0);
    chk("frame1_code", ir_out, 32'h20DF_5BA4);

    snap();
    send_repeat();
    chk("repeat_pulse", n_rep - r0, 1);
    chk("repeat_err", n_errp - e0, 0);
    chk("repeat_code", ir_out, 32'h20DF_5BA4);

    snap();
    send_frame(32'h20DF_5BA5);
    chk("badinv_err", n_errp - e0, 1);
    chk("badinv_valid", n_valid - v0, 0);
    chk("badinv_code", ir_out, 32'h20DF_5BA4);
    chk("noinv_valid", n_valid2 - w0, 1);
    chk("noinv_code", ir_out2, 32'h20DF_5BA5);

    snap();
    hold(1'b0, 6000);
    hold(1'b1, 50);
    chk("short_lead_err", n_errp - e0, 1);
    hold(1'b1, 3000);
    snap();
    send_frame(32'h20DF_5AA5);
    chk("frame2_valid", n_valid - v0, 1);
    chk("frame2_code", ir_out, 32'h20DF_5AA5);

    snap();
    c = 32'h20DF_5BA4;
    hold(1'b0, 9000);
    hold(1'b1, 4500);
    for (int i = 31; i >= 12; i--) send_bit(c[i]);
    hold(1'b1, 8000);
    chk("timeout_early", n_errp - e0, 0);
    hold(1'b1, 3000);
    chk("timeout_err", n_errp - e0, 1);
    chk("timeout_valid", n_valid - v0, 0);
    snap();
    send_frame(32'h20DF_5BA4);
    chk("after_to_valid", n_valid - v0, 1);
    chk("after_to_code", ir_out, 32'h20DF_5BA4);

    snap();
    hold(1'b0, 9000);
    hold(1'b1, 4500);
    for (int i = 31; i >= 16; i--) send_bit(c[i]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ir_out", ir_out, 32'h0);
    chk("midrst_strobes", {29'd0, valid, rep, err}, 32'h0);
    hold(1'b1, 3000);
    snap();
    send_frame(32'h20DF_5BA4);
    chk("post_rst_valid", n_valid - v0, 1);
    chk("post_rst_err", n_errp - e0, 0);
    chk("post_rst_code", ir_out, 32'h20DF_5BA4);

    chk("strobe_exclusive", n_multi, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/nec_ir_decoder.md
Name: nec_ir_decoder

Overview:
- Receives the demodulated IR-receiver pin and decodes NEC remote frames into the 32-bit code word consumed by the game/display logic as ir_in.
- Example codes are 32'h20DF_5BA4 and 32'h20DF_5AA5.
- Measures mark and space durations in microsecond ticks, classifies leader, repeat and data bits, and checks the command inverse.
- Holds the last valid code and pulses valid, repeat and error strobes.

Parameters:
- TICK_CYCLES, 74, clk_in cycles per 1 µs timing tick (74.25 MHz pixel clock; 0.3% error is within tolerance).
- CHECK_INVERSE, 1, when 1 a frame is accepted only if code[15:8] == ~code[7:0].

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- ir_rx_in  input  1  raw IR receiver output, asynchronous, active-low (low = carrier present = mark)
- ir_out  output  32  last accepted code; first received bit in [31], last received bit in [0]
- valid_out  output  1  one-cycle pulse when ir_out is updated with a new frame
- repeat_out  output  1  one-cycle pulse on a valid NEC repeat frame
- error_out  output  1  one-cycle pulse on framing, timeout or inverse-check failure

Behaviour:
- Reset: ir_out=0, all strobes 0, state IDLE, have_code=0, synchronizer flops =1 (line idle), counters 0.
- Input path:
  - 2-flop synchronizer, then inversion to mark=1.
  - Edge detect on the synchronized level.
  - Edge-to-decision latency is 3 cycles: 2 sync + 1 register. Strobes assert on the cycle after the state logic sees the edge.
- Duration counter:
  - Prescaler counts 0..TICK_CYCLES-1.
  - 14-bit µs counter increments on prescaler wrap and saturates at 16383.
  - Both counters clear on every synchronized edge.
  - Each mark/space is classified by the µs count at the edge that ends it.
- Windows (µs, inclusive):
  - Leader mark 8000–10000.
  - Data space 4000–5000; repeat space 1800–2700.
  - Bit mark 350–800.
  - Bit space: 350–800 = 0, 1400–2000 = 1.
- States and transitions:
  - IDLE: mark start -> LEAD_MARK.
  - LEAD_MARK: mark end in window -> LEAD_SPACE; otherwise error.
  - LEAD_SPACE: mark start with data space -> BIT_MARK (bit count=0); with repeat space -> REP_MARK; otherwise error.
  - BIT_MARK: mark end in window -> BIT_SPACE; otherwise error.
  - BIT_SPACE: next mark start classifies the bit; shift code {code[30:0], bit}; count++. After bit 31, the stop-mark start completes the frame -> FINISH; otherwise -> BIT_MARK. An invalid space is an error.
  - FINISH (1 cycle): if the inverse check passes (or CHECK_INVERSE=0), ir_out<=code, valid_out=1, have_code=1; else error_out=1, ir_out unchanged. Then -> IDLE.
  - REP_MARK (entered at burst start): if have_code, repeat_out=1 on entry, else error_out=1. Then -> IDLE.
- The trailing stop mark and repeat burst are not length-checked; IDLE ignores the mark end.
- Timeout: in any non-IDLE state, a µs count above 10000 with no edge -> error_out pulse once, then IDLE.
- Error handling: error_out pulses exactly one cycle per failure, and state returns to IDLE. A mark start in the same cycle is not re-evaluated; the decoder waits for the next mark start.
- ir_out changes only in FINISH. Errors and repeats never modify ir_out.
- Reset mid-frame: everything returns to reset values immediately. If the line is low when reset is released, the next falling edge is treated as a normal mark start. A short partial leader yields an error pulse, which is acceptable.
- Strobes are mutually exclusive in any cycle.

Decomposition:
- Package ir_pkg holds:
  - state enum (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, FINISH, REP_MARK);
  - µs window constants (min/max per class);
  - TIMEOUT_US=10000;
  - counter width 14.
- One sub-module, ir_pulse_timer: synchronizer, edge detect (mark_start, mark_end), prescaler and saturating µs counter.
- nec_ir_decoder holds the FSM, shift register and outputs.

Test Plan:
- Bench setup: TICK_CYCLES=4 for speed; all timings stimulated in µs × 4 cycles.
- Full frame 9000/4500, 32 bits of 0x20DF5BA4 MSB-first, stop mark 562 -> exactly one valid_out, ir_out=0x20DF5BA4, no error.
- After that frame, repeat 9000/2250/562 -> one repeat_out, ir_out still 0x20DF5BA4. The same repeat right after reset -> error_out, no repeat_out.
- Frame 0x20DF5BA5 (bad inverse) -> error_out pulse, no valid_out, ir_out unchanged. With CHECK_INVERSE=0 -> valid_out, ir_out=0x20DF5BA5.
- Leader mark 6000 µs -> error_out at mark end. Then a good 0x20DF5AA5 frame -> valid_out, ir_out=0x20DF5AA5.
- 20 bits, then line held idle -> single error_out about 10000 µs after the last edge, state IDLE. The next good frame decodes.
- rst_in asserted for 1 cycle at bit 16 -> all outputs 0 on the following cycle. The next full 0x20DF5BA4 frame decodes correctly.
